// File: rtl/game_flow_controller_if.sv
// Key inputs, score-controller flags and flow outputs of the match sequencer.
// The controller takes the slave view; whatever drives the keys takes the master view.
interface game_flow_controller_if;
    logic       startKey;
    logic       pauseKey;
    logic       tank1Win;
    logic       tank2Win;
    logic       tank1Lose;
    logic       tank2Lose;
    logic       one_sec;
    logic       countEn;
    logic       scoreResetN;
    logic [3:0] countdownDigit;
    logic [2:0] gameState;
    logic [1:0] winner;
    logic [6:0] timeLeft;

    modport master (
        output startKey, pauseKey, tank1Win, tank2Win, tank1Lose, tank2Lose,
        input  one_sec, countEn, scoreResetN, countdownDigit, gameState, winner, timeLeft
    );

    modport slave (
        input  startKey, pauseKey, tank1Win, tank2Win, tank1Lose, tank2Lose,
        output one_sec, countEn, scoreResetN, countdownDigit, gameState, winner, timeLeft
    );
endinterface

// File: rtl/game_flow_controller.sv
// Match sequencer: title/countdown/play/pause/game-over flow, one-second tick and score reset.
// Define MATCH_TIMER_EN to add the match time limit (timeLeft, timeout draw).
module game_flow_controller #(
    parameter int CLK_FREQ_HZ       = 25000000,
    parameter int COUNTDOWN_SEC     = 3,
    parameter int GAMEOVER_HOLD_SEC = 5,
    parameter int MATCH_TIME_SEC    = 99
) (
    input logic                   clk,
    input logic                   reset,
    game_flow_controller_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COUNTDOWN = 3'd1;
    localparam logic [2:0] PLAY      = 3'd2;
    localparam logic [2:0] PAUSE     = 3'd3;
    localparam logic [2:0] GAME_OVER = 3'd4;

`ifdef MATCH_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    localparam int              PW        = $clog2(CLK_FREQ_HZ);
    localparam int              HW        = $clog2(GAMEOVER_HOLD_SEC + 2);
    localparam logic [PW-1:0]   PS_LAST   = PW'(CLK_FREQ_HZ - 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(GAMEOVER_HOLD_SEC);
    localparam logic [3:0]      CD_LOAD   = 4'(COUNTDOWN_SEC);
    localparam logic [6:0]      TL_LOAD   = TIMER_EN ? 7'(MATCH_TIME_SEC) : 7'd0;

    logic [2:0]    state, state_n;
    logic [PW-1:0] cnt, cnt_n;
    logic          tick;
    logic [3:0]    digit, digit_n;
    logic [1:0]    winner, winner_n, flag_winner;
    logic          score_rst_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [6:0]    time_left, tl_n;
    logic          start_q, pause_q;
    logic          start_press, pause_press, flag, timeout, hold_done, enter_cd;

    assign start_press = bus.startKey & ~start_q;
    assign pause_press = bus.pauseKey & ~pause_q;
    assign flag        = bus.tank1Win | bus.tank2Win | bus.tank1Lose | bus.tank2Lose;
    assign hold_done   = (hold_cnt >= HOLD_LAST);
    assign timeout     = TIMER_EN && tick && (time_left == 7'd1);

    always_comb begin
        if (bus.tank1Win)       flag_winner = 2'b01;
        else if (bus.tank2Win)  flag_winner = 2'b10;
        else if (bus.tank1Lose) flag_winner = 2'b10;
        else                    flag_winner = 2'b01;
    end

    always_comb begin
        state_n  = state;
        digit_n  = digit;
        winner_n = winner;
        hold_n   = hold_cnt;
        tl_n     = time_left;
        enter_cd = 1'b0;
        case (state)
            IDLE: enter_cd = start_press;
            COUNTDOWN: begin
                if (tick) begin
                    if (digit == 4'd1) begin
                        state_n = PLAY;
                        digit_n = 4'd0;
                        tl_n    = TL_LOAD;
                    end else begin
                        digit_n = digit - 4'd1;
                    end
                end
            end
            PLAY: begin
                if (tick && time_left != 7'd0) tl_n = time_left - 7'd1;
                // Score flags outrank the timeout, which outranks pause.
                if (flag) begin
                    state_n  = GAME_OVER;
                    winner_n = flag_winner;
                end else if (timeout) begin
                    state_n  = GAME_OVER;
                    winner_n = 2'b11;
                end else if (pause_press) begin
                    state_n = PAUSE;
                end
                if (state_n == GAME_OVER) hold_n = '0;
            end
            PAUSE: if (pause_press) state_n = PLAY;
            GAME_OVER: begin
                if (tick && !hold_done) hold_n = hold_cnt + 1'b1;
                enter_cd = start_press && hold_done;
            end
            default: state_n = IDLE;
        endcase
        if (enter_cd) begin
            state_n  = COUNTDOWN;
            digit_n  = CD_LOAD;
            winner_n = 2'b00;
        end
        // Prescaler restarts on countdown entry and freezes while paused.
        if (enter_cd)             cnt_n = '0;
        else if (state == PAUSE)  cnt_n = cnt;
        else if (cnt == PS_LAST)  cnt_n = '0;
        else                      cnt_n = cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tick        <= 1'b0;
            digit       <= 4'd0;
            winner      <= 2'b00;
            score_rst_n <= 1'b1;
            hold_cnt    <= '0;
            time_left   <= 7'd0;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            tick        <= (cnt_n == PS_LAST) && (state_n != PAUSE);
            digit       <= digit_n;
            winner      <= winner_n;
            score_rst_n <= ~enter_cd;
            hold_cnt    <= hold_n;
            time_left   <= tl_n;
            start_q     <= bus.startKey;
            pause_q     <= bus.pauseKey;
        end
    end

    assign bus.one_sec        = tick;
    assign bus.countEn        = (state == PLAY);
    assign bus.scoreResetN    = score_rst_n;
    assign bus.countdownDigit = digit;
    assign bus.gameState      = state;
    assign bus.winner         = winner;
    assign bus.timeLeft       = time_left;
endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller: expectations are queued as stimulus is
// driven and popped when the corresponding output is sampled.
`timescale 1ns/1ps
module tb_game_flow_controller;
    localparam int CLK_HZ = 10;
    localparam int CD     = 3;
    localparam int HOLD   = 2;
    localparam int MT     = 5;
`ifdef MATCH_TIMER_EN
    localparam int TL0      = MT;
    localparam int HOLD_CYC = 15;
`else
    localparam int TL0      = 0;
    localparam int HOLD_CYC = 50;
`endif

    logic clk = 1'b0;
    logic reset;
    game_flow_controller_if bus();

    game_flow_controller #(
        .CLK_FREQ_HZ(CLK_HZ), .COUNTDOWN_SEC(CD),
        .GAMEOVER_HOLD_SEC(HOLD), .MATCH_TIME_SEC(MT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic obs(input string tag, input logic [31:0] act);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check(tag, act, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Steps until one_sec is seen; n is the number of cycles it took.
    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 0; i < 4 * CLK_HZ; i++) begin
            step(1);
            n++;
            if (bus.one_sec) break;
        end
        if (!bus.one_sec) check("tick_wait", bus.one_sec, 1);
    endtask

    task automatic wait_state(input logic [2:0] s);
        for (int i = 0; i < (CD + 2) * CLK_HZ; i++) begin
            if (bus.gameState == s) break;
            step(1);
        end
        check("state_wait", bus.gameState, s);
    endtask

    int n;
    int pause_ticks;

    initial begin
        reset = 1'b1;
        bus.startKey = 0; bus.pauseKey = 0;
        bus.tank1Win = 0; bus.tank2Win = 0; bus.tank1Lose = 0; bus.tank2Lose = 0;
        step(3);
        reset = 1'b0;
        push(0); push(0); push(1); push(0); push(0); push(0); push(0);
        step(1);
        obs("rst_state", bus.gameState);  obs("rst_counten", bus.countEn);
        obs("rst_scorerst", bus.scoreResetN); obs("rst_digit", bus.countdownDigit);
        obs("rst_winner", bus.winner);    obs("rst_onesec", bus.one_sec);
        obs("rst_timeleft", bus.timeLeft);

        // Pause press in IDLE does nothing
        bus.pauseKey = 1; push(0);
        step(2); obs("idle_pause", bus.gameState);
        bus.pauseKey = 0;
        step(1);

        // Start: countdown entry (E0), digit steps every CLK_HZ cycles, PLAY at E30
        bus.startKey = 1;
        push(1); push(3); push(0);
        step(1);
        obs("cd_state", bus.gameState); obs("cd_digit", bus.countdownDigit);
        obs("cd_scorerst_lo", bus.scoreResetN);
        push(1); push(1);
        step(1);
        obs("cd_scorerst_hi", bus.scoreResetN); obs("cd_state2", bus.gameState);
        push(3); push(1);
        step(8);
        obs("cd_digit_e9", bus.countdownDigit); obs("cd_tick_e9", bus.one_sec);
        push(2); push(0);
        step(1);
        obs("cd_digit_e10", bus.countdownDigit); obs("cd_tick_e10", bus.one_sec);
        push(1);
        step(10); obs("cd_digit_e20", bus.countdownDigit);
        push(1); push(0);
        step(9);
        obs("cd_state_e29", bus.gameState); obs("cd_counten_e29", bus.countEn);
        push(2); push(1); push(0); push(TL0);
        step(1);
        obs("play_state", bus.gameState); obs("play_counten", bus.countEn);
        obs("play_digit", bus.countdownDigit); obs("play_timeleft", bus.timeLeft);

        // Held start key in PLAY never changes state
        bus.startKey = 0;
        step(1);
        bus.startKey = 1;
        for (int i = 0; i < HOLD_CYC; i++) begin
            push(2); step(1); obs("start_hold", bus.gameState);
        end
        bus.startKey = 0;

        // Pause 3 cycles after a tick, start pressed together with pause
        wait_tick(n);
        step(3);
        bus.startKey = 1; bus.pauseKey = 1;
        push(3); push(0);
        step(1);
        obs("pause_state", bus.gameState); obs("pause_counten", bus.countEn);
        bus.startKey = 0;
        step(1);
        bus.startKey = 1;
        pause_ticks = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (bus.one_sec) pause_ticks++;
        end
        push(0); push(3);
        obs("pause_ticks", pause_ticks); obs("pause_hold", bus.gameState);
        bus.pauseKey = 0; bus.startKey = 0;
        step(1);
        bus.pauseKey = 1;
        push(2); push(1);
        step(1);
        obs("resume_state", bus.gameState); obs("resume_counten", bus.countEn);
        // Prescaler froze at 3, so 6 more active cycles reach the tick
        push(CLK_HZ - 4);
        wait_tick(n); obs("resume_gap", n);
        bus.pauseKey = 0;

        // Win and lose flags together: tank1Win has priority
        bus.tank1Win = 1; bus.tank2Lose = 1;
        push(4); push(1); push(0);
        step(1);
        obs("go_state", bus.gameState); obs("go_winner", bus.winner);
        obs("go_counten", bus.countEn);
        bus.tank1Win = 0; bus.tank2Lose = 0;

        // Start ignored until two ticks have elapsed in GAME_OVER
        bus.startKey = 1; push(4);
        step(2); obs("go_early_start", bus.gameState);
        bus.startKey = 0;
        wait_tick(n);
        step(1);
        bus.startKey = 1; push(4); push(1);
        step(1); obs("go_one_tick", bus.gameState); obs("go_winner_held", bus.winner);
        bus.startKey = 0;
        wait_tick(n);
        step(1);
        bus.startKey = 1;
        push(1); push(0); push(0); push(3);
        step(1);
        obs("restart_state", bus.gameState); obs("restart_winner", bus.winner);
        obs("restart_scorerst", bus.scoreResetN); obs("restart_digit", bus.countdownDigit);
        push(2);
        step(10); obs("restart_digit2", bus.countdownDigit);

        // Asynchronous reset between clock edges
        #3 reset = 1'b1;
        #1;
        push(0); push(0); push(1); push(0); push(0); push(0); push(0);
        obs("areset_state", bus.gameState); obs("areset_digit", bus.countdownDigit);
        obs("areset_scorerst", bus.scoreResetN); obs("areset_counten", bus.countEn);
        obs("areset_winner", bus.winner); obs("areset_onesec", bus.one_sec);
        obs("areset_timeleft", bus.timeLeft);
        bus.startKey = 0;
        step(2);
        reset = 1'b0;
        step(1);

`ifdef MATCH_TIMER_EN
        // Timeout: timeLeft 5..1 on the ticks, then draw
        bus.startKey = 1;
        step(1);
        wait_state(3'd2);
        for (int i = 0; i < MT; i++) begin
            push(MT - i); wait_tick(n); obs("tl_tick", bus.timeLeft);
        end
        push(4); push(3);
        step(1);
        obs("timeout_state", bus.gameState); obs("timeout_winner", bus.winner);
        bus.startKey = 0;
        wait_tick(n); wait_tick(n);
        step(1);
        bus.startKey = 1;
        step(1);
        wait_state(3'd2);
        for (int i = 0; i < MT; i++) wait_tick(n);
        // Flag on the final tick outranks the timeout draw
        bus.tank2Win = 1;
        push(4); push(2);
        step(1);
        obs("timeout_flag_state", bus.gameState); obs("timeout_flag_winner", bus.winner);
        bus.tank2Win = 0;
        bus.startKey = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
